// File: rtl/keypad_code_ctrl.sv
// keypad_code_ctrl: collects a multi-digit PIN from key events, compares it with
// the stored code and emits a one-cycle arm/disarm command for the alarm FSM.
// Repeated failures lock the keypad for a fixed number of enabled cycles.
//
// Optional feature macro: KPC_DURESS_EN. When it is defined, the duress code
// (PIN with its last digit incremented mod 10) followed by DISARM disarms
// normally and also raises the sticky duress output.
//
// Key interface: key_valid is a strobe with no back-pressure. A key is consumed
// on any clock edge where ENA=1 and key_valid=1; with ENA=0 the key is simply
// not seen, so the source must hold key_valid/key_code across an enabled edge.
//
// All outputs are registered. Pulsed outputs (keypad_out, cmd_valid,
// entry_error) hold their value until the next ENA=1 edge.
module keypad_code_ctrl #(
  parameter int                    CODE_LEN    = 4,
  parameter logic [4*CODE_LEN-1:0] PIN         = 16'h1234,
  parameter int                    MAX_FAIL    = 3,
  parameter int                    LOCK_CYCLES = 200,
  parameter int                    TIMEOUT     = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ENA,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] keypad_out,
  output logic       cmd_valid,
  output logic       entry_error,
  output logic       locked,
  output logic [3:0] digit_count,
`ifdef KPC_DURESS_EN
  output logic       duress,
`endif
  output logic [1:0] state_dbg
);

  localparam int W  = 4 * CODE_LEN;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  localparam logic [3:0]    CODE_LEN_C   = 4'(CODE_LEN);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_LAST    = LW'(LOCK_CYCLES - 1);
  localparam logic [FW-1:0] MAX_FAIL_C   = FW'(MAX_FAIL);

  localparam logic [3:0] CMD_ARM    = 4'b0011;
  localparam logic [3:0] CMD_DISARM = 4'b1100;

`ifdef KPC_DURESS_EN
  // Duress code: same leading digits, last digit advanced by one (9 wraps to 0).
  localparam logic [3:0]   PIN_LAST    = PIN[3:0];
  localparam logic [3:0]   DURESS_LAST = (PIN_LAST == 4'd9) ? 4'd0 : PIN_LAST + 4'd1;
  localparam logic [W-1:0] DURESS_PIN  = ((PIN >> 4) << 4) | W'(DURESS_LAST);
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENTRY   = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;

  state_t        state_q,   state_d;
  logic [W-1:0]  buf_q,     buf_d;
  logic [3:0]    count_q,   count_d;
  logic          over_q,    over_d;
  logic [FW-1:0] fail_q,    fail_d;
  logic [TW-1:0] idle_q,    idle_d;
  logic [LW-1:0] lock_q,    lock_d;
  logic [3:0]    keypad_q,  keypad_d;
  logic          cmd_q,     cmd_d;
  logic          err_q,     err_d;
  logic          locked_q,  locked_d;
`ifdef KPC_DURESS_EN
  logic          duress_q,  duress_d;
  logic          duress_match;
`endif

  // Key classification; only meaningful on an enabled edge.
  logic          key_digit;
  logic          key_arm;
  logic          key_disarm;
  logic          key_clear;
  logic          full_entry;
  logic          pin_match;
  logic [W-1:0]  buf_shift;
  logic [FW-1:0] fail_inc;

  // Decode the key and precompute the shifted buffer and match conditions.
  always_comb begin
    key_digit  = key_valid && (key_code <= 4'd9);
    key_arm    = key_valid && (key_code == 4'hA);
    key_disarm = key_valid && (key_code == 4'hB);
    key_clear  = key_valid && (key_code == 4'hC);
    buf_shift        = buf_q << 4;
    buf_shift[3:0]   = key_code;
    full_entry = (count_q == CODE_LEN_C) && !over_q;
    pin_match  = full_entry && (buf_q == PIN);
    fail_inc   = fail_q + FW'(1);
`ifdef KPC_DURESS_EN
    duress_match = full_entry && (buf_q == DURESS_PIN);
`endif
  end

  // State and output registers; reset wins over ENA, nothing moves while ENA=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      buf_q    <= '0;
      count_q  <= '0;
      over_q   <= 1'b0;
      fail_q   <= '0;
      idle_q   <= '0;
      lock_q   <= '0;
      keypad_q <= 4'b0000;
      cmd_q    <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
`ifdef KPC_DURESS_EN
      duress_q <= 1'b0;
`endif
    end else if (ENA) begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      count_q  <= count_d;
      over_q   <= over_d;
      fail_q   <= fail_d;
      idle_q   <= idle_d;
      lock_q   <= lock_d;
      keypad_q <= keypad_d;
      cmd_q    <= cmd_d;
      err_q    <= err_d;
      locked_q <= locked_d;
`ifdef KPC_DURESS_EN
      duress_q <= duress_d;
`endif
    end
  end

  // Next-state and next-output logic for one enabled edge.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    count_d  = count_q;
    over_d   = over_q;
    fail_d   = fail_q;
    idle_d   = idle_q;
    lock_d   = lock_q;
    keypad_d = 4'b0000;
    cmd_d    = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;
`ifdef KPC_DURESS_EN
    duress_d = duress_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Only a digit starts an entry; commands with nothing entered are ignored.
        if (key_digit) begin
          buf_d   = W'(key_code);
          count_d = 4'd1;
          over_d  = 1'b0;
          idle_d  = '0;
          state_d = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (key_digit) begin
          idle_d = '0;
          if (count_q < CODE_LEN_C) begin
            buf_d   = buf_shift;
            count_d = count_q + 4'd1;
          end else begin
            // Too many digits: remember it so the attempt can never match.
            over_d = 1'b1;
          end
        end else if (key_clear) begin
          state_d = S_IDLE;
        end else if (key_arm || key_disarm) begin
          state_d = S_IDLE;
          if (pin_match) begin
            keypad_d = key_arm ? CMD_ARM : CMD_DISARM;
            cmd_d    = 1'b1;
            fail_d   = '0;
          end
`ifdef KPC_DURESS_EN
          else if (key_disarm && duress_match) begin
            // Silent alarm: disarm as usual, leave the failure count alone.
            keypad_d = CMD_DISARM;
            cmd_d    = 1'b1;
            duress_d = 1'b1;
          end
`endif
          else begin
            err_d  = 1'b1;
            fail_d = fail_inc;
            if (fail_inc == MAX_FAIL_C) begin
              state_d  = S_LOCKOUT;
              locked_d = 1'b1;
              lock_d   = '0;
            end
          end
        end else if (idle_q == TIMEOUT_LAST) begin
          // Abandoned entry: discard quietly, not a failed attempt.
          state_d = S_IDLE;
        end else begin
          idle_d = idle_q + TW'(1);
        end

        // Any exit from ENTRY discards the partial code.
        if (state_d != S_ENTRY) begin
          buf_d   = '0;
          count_d = '0;
          over_d  = 1'b0;
          idle_d  = '0;
        end
      end

      S_LOCKOUT: begin
        // Keys are ignored; release after exactly LOCK_CYCLES enabled cycles.
        if (lock_q == LOCK_LAST) begin
          state_d  = S_IDLE;
          locked_d = 1'b0;
          fail_d   = '0;
          lock_d   = '0;
        end else begin
          lock_d = lock_q + LW'(1);
        end
      end

      default: begin
        state_d  = S_IDLE;
        locked_d = 1'b0;
      end
    endcase
  end

  // Registered outputs.
  always_comb begin
    keypad_out  = keypad_q;
    cmd_valid   = cmd_q;
    entry_error = err_q;
    locked      = locked_q;
    digit_count = count_q;
    state_dbg   = state_q;
`ifdef KPC_DURESS_EN
    duress      = duress_q;
`endif
  end

endmodule
